// File: rtl/fir_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_sched
//  Description : Time-multiplexed FIR controller. One external signed
//                multiplier is shared across all taps; each accepted sample
//                takes TAPS multiply-accumulate cycles, then the result is
//                offered on a valid/ready output port.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_sched #(
    parameter int TAPS = 8,
    parameter int DW   = 9,
    parameter int CW   = 10,
    parameter int AW   = 24,
    localparam int TW  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic          clk,
    input  logic          rst,

    // sample input
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,

    // coefficient write port
    input  logic          coef_wr_en,
    input  logic [TW-1:0] coef_wr_addr,
    input  logic [CW-1:0] coef_wr_data,
    output logic          coef_wr_rdy,

    // shared external multiplier
    output logic [DW-1:0] mul_a,
    output logic [CW-1:0] mul_b,
    input  logic [AW-1:0] mul_p,

    // filter output
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,

    output logic          busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Index of the last tap; reaching it in MAC ends the pass.
    localparam logic [TW-1:0] C_LAST_TAP = TW'(TAPS - 1);
    // Tap count at address width + 1 so out-of-range addresses can be caught
    // even when TAPS is a power of two.
    localparam logic [TW:0]   C_TAPS     = (TW + 1)'(TAPS);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                state_q;
    logic signed [DW-1:0]  x_q [TAPS];      // sample delay line, x_q[0] newest
    logic signed [CW-1:0]  c_q [TAPS];      // coefficient bank
    logic        [AW-1:0]  acc_q;
    logic        [AW-1:0]  acc_d;
    logic        [TW-1:0]  idx_q;
    logic                  out_valid_q;
    logic        [AW-1:0]  out_data_q;

    logic                  coef_addr_ok;
    logic                  coef_wr_fire;
    logic                  in_fire;

    // ------------------------------------------------------------------------
    // Handshake and status decode
    // ------------------------------------------------------------------------
    // Samples are only taken in IDLE, so no result can ever be overwritten.
    assign in_ready     = (state_q == ST_IDLE);
    // The bank is read during MAC; freezing it there keeps a pass coherent.
    assign coef_wr_rdy  = (state_q != ST_MAC);
    assign busy         = (state_q != ST_IDLE);

    assign in_fire      = in_valid & in_ready;
    assign coef_addr_ok = ({1'b0, coef_wr_addr} < C_TAPS);
    assign coef_wr_fire = coef_wr_en & coef_wr_rdy & coef_addr_ok;

    // Multiplier operands come straight from the registers at the current
    // tap so the product arrives in the same cycle; held at zero otherwise.
    assign mul_a = (state_q == ST_MAC) ? x_q[idx_q] : '0;
    assign mul_b = (state_q == ST_MAC) ? c_q[idx_q] : '0;

    // The multiplier hands back a sign-extended product, so a plain modulo
    // 2^AW add gives correct two's-complement accumulation.
    assign acc_d = acc_q + mul_p;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // ------------------------------------------------------------------------
    // Control FSM with datapath registers (delay line, coefficients, acc)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            // Coefficient updates are independent of the sample flow; a write
            // coinciding with sample acceptance is visible to that pass.
            if (coef_wr_fire) begin
                c_q[coef_wr_addr] <= coef_wr_data;
            end

            case (state_q)
                ST_IDLE: begin
                    if (in_fire) begin
                        x_q[0] <= in_data;
                        for (int k = 1; k < TAPS; k++) begin
                            x_q[k] <= x_q[k-1];
                        end
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ST_MAC;
                    end
                end

                ST_MAC: begin
                    acc_q <= acc_d;
                    if (idx_q == C_LAST_TAP) begin
                        // Final product folded straight into the output
                        // register so the result is ready on entry to OUT.
                        idx_q       <= '0;
                        out_data_q  <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end

                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_mac_sched
//  Description : Self-checking bench for fir_mac_sched. A transaction-level
//                model (dot product of delay line and coefficient bank) is
//                compared against the DUT every cycle, plus directed
//                scenarios with hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sched;

    localparam int TAPS = 8;
    localparam int DW   = 9;
    localparam int CW   = 10;
    localparam int AW   = 24;
    localparam int TW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          coef_wr_en;
    logic [TW-1:0] coef_wr_addr;
    logic [CW-1:0] coef_wr_data;
    logic          coef_wr_rdy;
    logic [DW-1:0] mul_a;
    logic [CW-1:0] mul_b;
    logic [AW-1:0] mul_p;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          busy;

    always #5 clk = ~clk;

    // External signed multiplier: sign-extended product of the operands.
    logic signed [AW-1:0] prod;
    assign prod  = $signed(mul_a) * $signed(mul_b);
    assign mul_p = prod;

    fir_mac_sched #(.TAPS(TAPS), .DW(DW), .CW(CW), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .coef_wr_rdy  (coef_wr_rdy),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_p        (mul_p),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    int acc_prev = 0;
    int rise_cyc = 0;
    logic prev_ov = 1'b0;
    logic chk_en  = 1'b0;
    logic [AW-1:0] got_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Reference model: phase 0 idle, 1 multiply-accumulate, 2 output.
    // The result is the plain dot product of the delay line and the bank.
    // ------------------------------------------------------------------------
    logic signed [DW-1:0] m_x [TAPS];
    logic signed [CW-1:0] m_c [TAPS];
    int                   m_phase;
    int                   m_k;
    logic [AW-1:0]        m_res;

    function automatic logic [AW-1:0] dot();
        int s;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += int'(m_x[k]) * int'(m_c[k]);
        return s[AW-1:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_k     <= 0;
            m_res   <= '0;
            for (int k = 0; k < TAPS; k++) begin
                m_x[k] <= '0;
                m_c[k] <= '0;
            end
        end else begin
            if (coef_wr_en && m_phase != 1 && int'(coef_wr_addr) < TAPS)
                m_c[coef_wr_addr] <= coef_wr_data;
            if (m_phase == 0) begin
                if (in_valid) begin
                    m_x[0] <= in_data;
                    for (int k = 1; k < TAPS; k++) m_x[k] <= m_x[k-1];
                    m_phase <= 1;
                    m_k     <= 0;
                end
            end else if (m_phase == 1) begin
                if (m_k == TAPS - 1) begin
                    m_res   <= dot();
                    m_phase <= 2;
                    m_k     <= 0;
                end else begin
                    m_k <= m_k + 1;
                end
            end else begin
                if (out_ready) m_phase <= 0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Compare process: every cycle, away from the active edge
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        logic [DW-1:0] ea;
        logic [CW-1:0] eb;
        if (!rst && chk_en) begin
            ea = (m_phase == 1) ? m_x[m_k] : '0;
            eb = (m_phase == 1) ? m_c[m_k] : '0;
            check("in_ready",    in_ready,    m_phase == 0);
            check("busy",        busy,        m_phase != 0);
            check("coef_wr_rdy", coef_wr_rdy, m_phase != 1);
            check("out_valid",   out_valid,   m_phase == 2);
            check("mul_a",       mul_a,       ea);
            check("mul_b",       mul_b,       eb);
            if (m_phase == 2) check("out_data", out_data, m_res);
            if (out_valid && !prev_ov) rise_cyc = cyc;
            if (out_valid && out_ready) got_q.push_back(out_data);
        end
        prev_ov = out_valid;
    end

    // ------------------------------------------------------------------------
    // Driver helpers (inputs change 2 time units after the rising edge)
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_coef(input int a, input int d);
        coef_wr_en   = 1'b1;
        coef_wr_addr = a[TW-1:0];
        coef_wr_data = d[CW-1:0];
        step();
        coef_wr_en   = 1'b0;
    endtask

    task automatic send(input int s);
        int b;
        b = 0;
        in_valid = 1'b1;
        in_data  = s[DW-1:0];
        while (!in_ready && b < 200) begin
            step();
            b++;
        end
        if (b >= 200) check("send_timeout", 0, 1);
        step();
        acc_prev = acc_cyc;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_n(input int n);
        int b;
        b = 0;
        while (got_q.size() < n && b < 300) begin
            step();
            b++;
        end
        if (b >= 300) check("output_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check("rst_out_valid",   out_valid,   1'b0);
        check("rst_out_data",    out_data,    '0);
        check("rst_mul_a",       mul_a,       '0);
        check("rst_mul_b",       mul_b,       '0);
        check("rst_busy",        busy,        1'b0);
        check("rst_in_ready",    in_ready,    1'b1);
        check("rst_coef_wr_rdy", coef_wr_rdy, 1'b1);
        rst = 1'b0;
        step();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int base;
        int v;
        logic [AW-1:0] d0;
        int b;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
        step();
        do_reset();
        chk_en = 1'b1;

        // Impulse response with c[k] = k+1.
        for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1);
        base = got_q.size();
        for (int i = 0; i <= TAPS; i++) begin
            send(i == 0 ? 1 : 0);
            wait_n(base + i + 1);
            if (got_q.size() > base + i)
                check($sformatf("impulse_%0d", i), got_q[base + i], (i < TAPS) ? i + 1 : 0);
            // out_valid is first seen TAPS edges after the acceptance edge,
            // i.e. in the (TAPS+1)th cycle counting the acceptance cycle.
            if (i == 0) check("latency_edges", rise_cyc - acc_cyc, TAPS);
            if (i == 1) check("accept_period", acc_cyc - acc_prev, TAPS + 2);
        end

        // Signed extremes.
        wr_coef(0, -512);
        for (int k = 1; k < TAPS; k++) wr_coef(k, 0);
        base = got_q.size();
        send(-256);
        wait_n(base + 1);
        if (got_q.size() > base) check("ext_neg_neg", got_q[base], 24'h020000);
        wr_coef(0, 511);
        send(-256);
        wait_n(base + 2);
        if (got_q.size() > base + 1) check("ext_pos_neg", got_q[base + 1], 24'hFE0100);

        // Full-scale accumulation from a clean delay line.
        do_reset();
        for (int k = 0; k < TAPS; k++) wr_coef(k, 511);
        base = got_q.size();
        for (int n = 1; n <= TAPS; n++) begin
            send(-256);
            wait_n(base + n);
            v = -130816 * n;
            if (got_q.size() >= base + n)
                check($sformatf("fullscale_%0d", n), got_q[base + n - 1], v[AW-1:0]);
        end
        if (got_q.size() >= base + TAPS) check("fullscale_final", got_q[base + TAPS - 1], 24'hF00800);

        // Backpressure: result must hold, extra in_valid pulses ignored.
        out_ready = 1'b0;
        send(7);
        b = 0;
        while (!out_valid && b < 50) begin step(); b++; end
        check("bp_reached_out", out_valid, 1'b1);
        d0 = out_data;
        v = 7 * 511 - 7 * 256 * 511;
        check("bp_value", d0, v[AW-1:0]);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            in_data  = 9'($urandom);
            step();
        end
        in_valid = 1'b0;
        check("bp_hold_valid",   out_valid, 1'b1);
        check("bp_hold_data",    out_data,  d0);
        check("bp_hold_inready", in_ready,  1'b0);
        base = got_q.size();
        out_ready = 1'b1;
        step();
        check("bp_release_inready", in_ready, 1'b1);
        check("bp_transfer_count",  got_q.size(), base + 1);

        // Coefficient write during MAC is dropped; repeated in IDLE it lands.
        base = got_q.size();
        send(3);
        coef_wr_en = 1'b1; coef_wr_addr = 3'd0; coef_wr_data = 10'd100;
        check("mac_wr_rdy_low", coef_wr_rdy, 1'b0);
        step();
        coef_wr_en = 1'b0;
        wait_n(base + 1);
        v = (3 + 7 - 6 * 256) * 511;
        if (got_q.size() > base) check("mac_wr_dropped", got_q[base], v[AW-1:0]);
        wr_coef(0, 100);
        send(0);
        wait_n(base + 2);
        v = 511 * (3 + 7 - 5 * 256);
        if (got_q.size() > base + 1) check("idle_wr_applied", got_q[base + 1], v[AW-1:0]);

        // Reset in the third MAC cycle.
        send(9);
        step();
        step();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_mul_a",     mul_a,     '0);
        check("midrst_mul_b",     mul_b,     '0);
        check("midrst_busy",      busy,      1'b0);
        step();
        rst = 1'b0;
        step();
        wr_coef(0, 2);
        base = got_q.size();
        send(5);
        wait_n(base + 1);
        if (got_q.size() > base) check("after_rst", got_q[base], 24'd10);

        // Randomized traffic checked cycle by cycle against the model.
        base = got_q.size();
        for (int i = 0; i < 800; i++) begin
            out_ready    = ($urandom_range(0, 3) != 0);
            in_valid     = $urandom_range(0, 1);
            in_data      = 9'($urandom);
            coef_wr_en   = ($urandom_range(0, 3) == 0);
            coef_wr_addr = 3'($urandom);
            coef_wr_data = 10'($urandom);
            step();
        end
        in_valid = 1'b0; coef_wr_en = 1'b0; out_ready = 1'b1;
        b = 0;
        while (busy && b < 50) begin step(); b++; end
        check("rand_drained", busy, 1'b0);
        check("rand_outputs_seen", got_q.size() > base + 10, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
